// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: holds one instruction, classifies its immediate
// format, and runs the IF/EX valid/ready handshake with load-use bubbles and flush.
module id_issue_ctrl #(
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_valid,
    input  logic [15:0]            if_instr,
    output logic                   if_ready,
    input  logic                   ex_ready,
    input  logic                   ex_load,
    input  logic [3:0]             ex_rd,
    input  logic                   flush,
    input  logic                   clr_stats,
    output logic                   id_valid,
    output logic [3:0]             id_opcode,
    output logic [3:0]             id_one,
    output logic [3:0]             id_two,
    output logic [3:0]             id_three,
    output logic [1:0]             id_imm_sel,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        VALID = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [1:0] FMT_A = 2'b00;
    localparam logic [1:0] FMT_B = 2'b01;
    localparam logic [1:0] FMT_C = 2'b10;
    localparam logic [1:0] FMT_D = 2'b11;

    state_t      state;
    logic [15:0] ir;
    logic        hazard;
    logic        fire;
    logic        uses_one;
    logic        uses_two;

    assign id_opcode = ir[15:12];
    assign id_one    = ir[11:8];
    assign id_two    = ir[7:4];
    assign id_three  = ir[3:0];
    assign state_dbg = state;

    always_comb begin
        id_imm_sel = FMT_A;
        case (id_opcode)
            4'b1000, 4'b1011:          id_imm_sel = FMT_B;
            4'b0100, 4'b0101, 4'b0110: id_imm_sel = FMT_C;
            4'b1100, 4'b1111:          id_imm_sel = FMT_D;
            default:                   id_imm_sel = FMT_A;
        endcase
    end

    // D-type reads no registers; only B-type reads field two.
    assign uses_one = (id_imm_sel != FMT_D);
    assign uses_two = (id_imm_sel == FMT_B);

    assign hazard = (state != EMPTY) && ex_load && (ex_rd != 4'd0) &&
                    ((uses_one && (ex_rd == id_one)) || (uses_two && (ex_rd == id_two)));

    // Handshake: a transfer happens on an edge where valid and ready are both high.
    assign id_valid = (state != EMPTY) && !hazard;
    assign stall    = hazard;
    assign fire     = id_valid && ex_ready;
    assign if_ready = !flush && ((state == EMPTY) || fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            ir    <= 16'h0000;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (if_valid) begin
                        ir    <= if_instr;
                        state <= VALID;
                    end
                end
                VALID, STALL: begin
                    // A cleared stall behaves exactly like VALID for that cycle.
                    if (hazard) begin
                        state <= STALL;
                    end else if (fire && if_valid) begin
                        ir    <= if_instr;
                        state <= VALID;
                    end else if (fire) begin
                        state <= EMPTY;
                    end else begin
                        state <= VALID;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (clr_stats) begin
            stall_cnt <= '0;
        end else if ((state == STALL) && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: reset, issue, backpressure, load-use,
// false-hazard cases, flush, counter saturation and clear.
module tb_id_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        if_ready;
    logic        ex_ready;
    logic        ex_load;
    logic [3:0]  ex_rd;
    logic        flush;
    logic        clr_stats;
    logic        id_valid;
    logic [3:0]  id_opcode, id_one, id_two, id_three;
    logic [1:0]  id_imm_sel;
    logic        stall;
    logic [1:0]  stall_cnt;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    id_issue_ctrl #(.STALL_CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_ready   (if_ready),
        .ex_ready   (ex_ready),
        .ex_load    (ex_load),
        .ex_rd      (ex_rd),
        .flush      (flush),
        .clr_stats  (clr_stats),
        .id_valid   (id_valid),
        .id_opcode  (id_opcode),
        .id_one     (id_one),
        .id_two     (id_two),
        .id_three   (id_three),
        .id_imm_sel (id_imm_sel),
        .stall      (stall),
        .stall_cnt  (stall_cnt),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1 step later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b1; if_instr = 16'h4A5C;
        ex_ready = 1'b1; ex_load = 1'b0; ex_rd = 4'd0; flush = 1'b0; clr_stats = 1'b0;

        // Reset
        #1;
        check("rst_if_ready", {15'd0, if_ready}, 16'd1);
        check("rst_id_valid", {15'd0, id_valid}, 16'd0);
        check("rst_stall", {15'd0, stall}, 16'd0);
        check("rst_stall_cnt", {14'd0, stall_cnt}, 16'd0);
        check("rst_imm_sel", {14'd0, id_imm_sel}, 16'd0);
        check("rst_opcode", {12'd0, id_opcode}, 16'd0);
        tick(); tick();
        check("rst_held_valid", {15'd0, id_valid}, 16'd0);
        rst_n = 1'b1;

        // Single issue of C-type 0x4A5C
        tick();
        if_valid = 1'b0;
        #1;
        check("issue_valid", {15'd0, id_valid}, 16'd1);
        check("issue_fields", {id_opcode, id_one, id_two, id_three}, 16'h4A5C);
        check("issue_imm_sel", {14'd0, id_imm_sel}, 16'd2);
        check("issue_if_ready", {15'd0, if_ready}, 16'd1);
        tick();
        check("issue_empty", {15'd0, id_valid}, 16'd0);
        check("issue_hold_fields", {id_opcode, id_one, id_two, id_three}, 16'h4A5C);

        // Backpressure then zero-bubble back-to-back issue
        if_valid = 1'b1; if_instr = 16'h1234; ex_ready = 1'b0;
        tick();
        if_instr = 16'hC300;
        #1;
        check("bp_valid", {15'd0, id_valid}, 16'd1);
        check("bp_if_ready", {15'd0, if_ready}, 16'd0);
        tick();
        check("bp_held", {id_opcode, id_one, id_two, id_three}, 16'h1234);
        ex_ready = 1'b1;
        #1;
        check("bp_if_ready_fire", {15'd0, if_ready}, 16'd1);
        tick();
        if_valid = 1'b0;
        #1;
        check("b2b_fields", {id_opcode, id_one, id_two, id_three}, 16'hC300);
        check("b2b_imm_sel", {14'd0, id_imm_sel}, 16'd3);
        check("b2b_valid", {15'd0, id_valid}, 16'd1);
        // D-type reads no registers
        ex_load = 1'b1; ex_rd = 4'd3;
        #1;
        check("dtype_no_stall", {15'd0, stall}, 16'd0);
        check("dtype_valid", {15'd0, id_valid}, 16'd1);
        ex_load = 1'b0;
        tick();
        check("b2b_drain", {15'd0, id_valid}, 16'd0);

        // Load-use on B-type 0x8320
        if_valid = 1'b1; if_instr = 16'h8320;
        tick();
        if_valid = 1'b0; ex_load = 1'b1; ex_rd = 4'd3;
        #1;
        check("lu_valid", {15'd0, id_valid}, 16'd0);
        check("lu_stall", {15'd0, stall}, 16'd1);
        check("lu_if_ready", {15'd0, if_ready}, 16'd0);
        check("lu_imm_sel", {14'd0, id_imm_sel}, 16'd1);
        ex_rd = 4'd2;
        #1;
        check("lu_field_two", {15'd0, stall}, 16'd1);
        tick();
        check("lu_state_stall", {14'd0, state_dbg}, 16'd2);
        check("lu_cnt_entry", {14'd0, stall_cnt}, 16'd0);
        ex_load = 1'b0;
        #1;
        check("lu_release_valid", {15'd0, id_valid}, 16'd1);
        check("lu_release_stall", {15'd0, stall}, 16'd0);
        tick();
        check("lu_cnt", {14'd0, stall_cnt}, 16'd1);
        check("lu_done", {15'd0, id_valid}, 16'd0);

        // A-type 0x1034: zero ex_rd and field-two match never stall
        if_valid = 1'b1; if_instr = 16'h1034; ex_ready = 1'b0;
        tick();
        if_valid = 1'b0; ex_load = 1'b1; ex_rd = 4'd0;
        #1;
        check("zero_rd_no_stall", {15'd0, stall}, 16'd0);
        ex_rd = 4'd3;
        #1;
        check("atype_two_no_stall", {15'd0, stall}, 16'd0);
        ex_load = 1'b0; ex_ready = 1'b1;
        tick();

        // A-type 0x2340: field two is not a source, field one is
        if_valid = 1'b1; if_instr = 16'h2340; ex_ready = 1'b0;
        tick();
        if_valid = 1'b0; ex_load = 1'b1; ex_rd = 4'd4;
        #1;
        check("atype_rd4_no_stall", {15'd0, stall}, 16'd0);
        check("atype_rd4_valid", {15'd0, id_valid}, 16'd1);
        ex_rd = 4'd3;
        #1;
        check("atype_rd3_stall", {15'd0, stall}, 16'd1);

        // Five STALL-state edges saturate the 2-bit counter at 3
        repeat (6) tick();
        check("sat_cnt", {14'd0, stall_cnt}, 16'd3);
        check("sat_stall", {15'd0, stall}, 16'd1);
        flush = 1'b1;
        #1;
        check("flush_if_ready", {15'd0, if_ready}, 16'd0);
        tick();
        flush = 1'b0; ex_load = 1'b0;
        #1;
        check("flush_empty", {15'd0, id_valid}, 16'd0);
        check("flush_state", {14'd0, state_dbg}, 16'd0);
        check("flush_cnt_kept", {14'd0, stall_cnt}, 16'd3);
        check("flush_fields_held", {id_opcode, id_one, id_two, id_three}, 16'h2340);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        #1;
        check("clr_cnt", {14'd0, stall_cnt}, 16'd0);

        // Asynchronous reset in the middle of a stall
        if_valid = 1'b1; if_instr = 16'hB560; ex_ready = 1'b1;
        tick();
        if_valid = 1'b0; ex_load = 1'b1; ex_rd = 4'd6;
        tick();
        check("mid_stall_state", {14'd0, state_dbg}, 16'd2);
        tick();
        check("mid_stall_cnt", {14'd0, stall_cnt}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_stall", {15'd0, stall}, 16'd0);
        check("async_rst_cnt", {14'd0, stall_cnt}, 16'd0);
        check("async_rst_ir", {id_opcode, id_one, id_two, id_three}, 16'h0000);
        check("async_rst_if_ready", {15'd0, if_ready}, 16'd1);
        ex_load = 1'b0;
        tick();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
